// File: rtl/scsi_io_arbiter_if.sv
// scsi_io_arbiter_if: sector-request and sector-buffer bus between the scsi targets and the IO controller
interface scsi_io_arbiter_if #(parameter int NUM_TGT = 2);
  logic [32*NUM_TGT-1:0] tgt_lba;
  logic [NUM_TGT-1:0] tgt_rd, tgt_wr, tgt_ack, tgt_buff_wr;
  logic [8*NUM_TGT-1:0] tgt_buff_din;
  logic [31:0] host_lba;
  logic host_rd, host_wr, host_ack, host_buff_wr;
  logic [7:0] host_buff_din;
  modport slave (input tgt_lba, tgt_rd, tgt_wr, tgt_buff_din, host_ack, host_buff_wr,
                 output tgt_ack, tgt_buff_wr, host_lba, host_rd, host_wr, host_buff_din);
  modport master (output tgt_lba, tgt_rd, tgt_wr, tgt_buff_din, host_ack, host_buff_wr,
                  input tgt_ack, tgt_buff_wr, host_lba, host_rd, host_wr, host_buff_din);
endinterface

// File: rtl/scsi_io_arbiter.sv
// scsi_io_arbiter: round-robin sharing of one IO-controller sector interface between NUM_TGT targets
module scsi_io_arbiter #(
  parameter int NUM_TGT = 2,
  parameter logic [23:0] TIMEOUT = 24'd10000000
) (
  input  logic clk,
  input  logic rst,
  scsi_io_arbiter_if.slave bus,
  output logic [2:0] grant_id,
  output logic busy,
  output logic timeout_err
);
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  state_t state_q, state_d;
  logic [2:0] grant_q, grant_d, rr_q, rr_d, win;
  logic [31:0] lba_q, lba_d, win_lba;
  logic [23:0] cnt_q, cnt_d;
  logic err_q, err_d, sel_rd, sel_wr, act;
  logic [7:0] sel_din;
  logic [NUM_TGT-1:0] req;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q <= 3'(NUM_TGT - 1);
      lba_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      lba_q <= lba_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // winner is the lowest requester above rr_q, else the lowest requester overall
  always_comb begin
    req = bus.tgt_rd | bus.tgt_wr;
    win = '0;
    win_lba = '0;
    sel_rd = 1'b0;
    sel_wr = 1'b0;
    sel_din = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) win = req[i] ? 3'(i) : win;
    for (int i = NUM_TGT - 1; i >= 0; i--) win = (req[i] && 3'(i) > rr_q) ? 3'(i) : win;
    for (int i = 0; i < NUM_TGT; i++) begin
      win_lba = (3'(i) == win) ? bus.tgt_lba[32*i +: 32] : win_lba;
      sel_rd = (3'(i) == grant_q) ? bus.tgt_rd[i] : sel_rd;
      sel_wr = (3'(i) == grant_q) ? bus.tgt_wr[i] : sel_wr;
      sel_din = (3'(i) == grant_q) ? bus.tgt_buff_din[8*i +: 8] : sel_din;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    lba_d = lba_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        state_d = GRANT;
        grant_d = win;
        lba_d = win_lba;
        cnt_d = '0;
      end
      GRANT: if (bus.host_ack) state_d = ACK;
        else if (!(sel_rd | sel_wr)) begin
          state_d = IDLE;
          rr_d = grant_q;
        end else if (TIMEOUT != '0 && cnt_q == TIMEOUT - 24'd1) begin
          state_d = IDLE;
          rr_d = grant_q;
          err_d = 1'b1;
        end else cnt_d = cnt_q + 24'd1;
      ACK: if (!bus.host_ack) begin
        state_d = IDLE;
        rr_d = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // ack and write strobe only ever reach the granted target, never in IDLE
  always_comb begin
    act = state_q != IDLE;
    busy = act;
    grant_id = grant_q;
    timeout_err = err_q;
    bus.host_lba = lba_q;
    bus.host_rd = state_q == GRANT && sel_rd;
    bus.host_wr = state_q == GRANT && sel_wr;
    bus.host_buff_din = sel_din;
    bus.tgt_ack = '0;
    bus.tgt_buff_wr = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      bus.tgt_ack[i] = act && 3'(i) == grant_q && bus.host_ack;
      bus.tgt_buff_wr[i] = act && 3'(i) == grant_q && bus.host_buff_wr;
    end
  end
endmodule

// File: tb/tb_scsi_io_arbiter.sv
// tb_scsi_io_arbiter: scoreboard bench for the two-target arbiter with a short timeout
module tb_scsi_io_arbiter;
  typedef struct {logic [2:0] id; logic [31:0] lba;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] grant_id;
  logic busy, timeout_err;
  int checks = 0, failures = 0;
  exp_t sbq[$];
  logic in_txn = 1'b0;
  logic [31:0] cur_lba = '0;
  scsi_io_arbiter_if #(.NUM_TGT(2)) bus ();
  scsi_io_arbiter #(.NUM_TGT(2), .TIMEOUT(24'd16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst || !busy) in_txn <= 1'b0;
    else if (!in_txn && (bus.host_rd || bus.host_wr)) begin
      if (sbq.size() == 0) check("sb_empty", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_grant", 32'(grant_id), 32'(e.id));
        check("sb_lba", bus.host_lba, e.lba);
        cur_lba <= e.lba;
      end
      in_txn <= 1'b1;
    end else if (in_txn) check("lba_hold", bus.host_lba, cur_lba);
  end
  task automatic wait_req();
    int n = 0;
    while (!(bus.host_rd || bus.host_wr) && n < 50) begin
      cyc();
      n++;
    end
    if (n == 50) check("wait_req", 0, 1);
  endtask
  task automatic serve(input logic [1:0] drop, input int n);
    logic [2:0] g;
    wait_req();
    g = grant_id;
    bus.host_ack = 1'b1;
    #1;
    check("ack_route", 32'(bus.tgt_ack), 32'd1 << g);
    repeat (n) cyc();
    check("ack_rd_low", 32'(bus.host_rd | bus.host_wr), 0);
    check("ack_hold", 32'(bus.tgt_ack), 32'd1 << g);
    bus.host_ack = 1'b0;
    bus.tgt_rd &= ~drop;
    bus.tgt_wr &= ~drop;
    #1;
    check("ack_fall", 32'(bus.tgt_ack), 0);
    cyc();
    check("idle_gap", 32'(busy), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0, c1, dm, te;
    logic [15:0] din;
    bus.tgt_lba = '0; bus.tgt_rd = '0; bus.tgt_wr = '0; bus.tgt_buff_din = '0;
    bus.host_ack = 1'b0; bus.host_buff_wr = 1'b0;
    cyc(); cyc();
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_lba", bus.host_lba, 0);
    check("rst_req", 32'({bus.host_rd, bus.host_wr, timeout_err}), 0);
    check("rst_tgt", 32'({bus.tgt_ack, bus.tgt_buff_wr}), 0);
    rst = 1'b0;
    // single target read
    bus.tgt_lba[31:0] = 32'h1234;
    bus.tgt_rd = 2'b01;
    sbq.push_back('{3'd0, 32'h1234});
    cyc();
    check("single_busy", 32'(busy), 1);
    check("single_rd", 32'(bus.host_rd), 1);
    serve(2'b01, 3);
    // contention: rr_last is 0 now, so 1, 0, 1
    bus.tgt_lba = {32'hB1B1_0001, 32'hA0A0_0000};
    bus.tgt_rd = 2'b11;
    sbq.push_back('{3'd1, 32'hB1B1_0001});
    sbq.push_back('{3'd0, 32'hA0A0_0000});
    sbq.push_back('{3'd1, 32'hB1B1_0001});
    serve(2'b00, 2);
    cyc();
    check("rr_lat_busy", 32'(busy), 1);
    check("rr_lat_id", 32'(grant_id), 0);
    serve(2'b00, 1);
    serve(2'b11, 1);
    // buffer routing through target 1
    bus.tgt_lba[63:32] = 32'h0000_5151;
    bus.tgt_rd = 2'b10;
    sbq.push_back('{3'd1, 32'h0000_5151});
    wait_req();
    bus.host_ack = 1'b1;
    c0 = 0; c1 = 0; dm = 0;
    for (int k = 0; k < 1024; k++) begin
      din = 16'($urandom);
      bus.tgt_buff_din = din;
      bus.host_buff_wr = (k % 2) == 0;
      #1;
      c0 += int'(bus.tgt_buff_wr[0]);
      c1 += int'(bus.tgt_buff_wr[1]);
      dm += int'(bus.host_buff_din != din[15:8]);
      cyc();
    end
    check("buf_wr1", c1, 512);
    check("buf_wr0", c0, 0);
    check("buf_din", dm, 0);
    bus.host_buff_wr = 1'b0;
    bus.host_ack = 1'b0;
    bus.tgt_rd = '0;
    cyc();
    check("buf_idle", 32'(busy), 0);
    bus.host_ack = 1'b1;
    bus.host_buff_wr = 1'b1;
    #1;
    check("idle_ack", 32'(bus.tgt_ack), 0);
    check("idle_bwr", 32'(bus.tgt_buff_wr), 0);
    cyc();
    check("idle_stay", 32'(busy), 0);
    bus.host_ack = 1'b0;
    bus.host_buff_wr = 1'b0;
    // timeout on target 0 write, target 1 waiting
    bus.tgt_lba = {32'h0000_00E1, 32'h0000_00E0};
    bus.tgt_wr = 2'b01;
    bus.tgt_rd = 2'b10;
    sbq.push_back('{3'd0, 32'h0000_00E0});
    sbq.push_back('{3'd1, 32'h0000_00E1});
    te = 0;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      te += int'(timeout_err);
      if (c == 5) bus.tgt_lba[31:0] = 32'hDEAD_0000;
    end
    check("to_early", te, 0);
    check("to_busy", 32'(busy), 1);
    cyc();
    check("to_pulse", 32'(timeout_err), 1);
    check("to_idle", 32'(busy), 0);
    cyc();
    check("to_once", 32'(timeout_err), 0);
    check("to_next", 32'(grant_id), 1);
    serve(2'b11, 2);
    // withdrawal before ack
    bus.tgt_lba[31:0] = 32'h0000_0A0A;
    bus.tgt_rd = 2'b01;
    sbq.push_back('{3'd0, 32'h0000_0A0A});
    cyc();
    check("wd_rd", 32'(bus.host_rd), 1);
    bus.tgt_rd = '0;
    #1;
    check("wd_rd_drop", 32'(bus.host_rd), 0);
    cyc();
    check("wd_idle", 32'(busy), 0);
    check("wd_err", 32'(timeout_err), 0);
    check("wd_ack", 32'(bus.tgt_ack), 0);
    // reset while in ACK
    bus.tgt_lba[31:0] = 32'h0000_7777;
    bus.tgt_rd = 2'b01;
    sbq.push_back('{3'd0, 32'h0000_7777});
    wait_req();
    bus.host_ack = 1'b1;
    cyc();
    check("ra_busy", 32'(busy), 1);
    rst = 1'b1;
    bus.tgt_rd = 2'b11;
    bus.tgt_lba[63:32] = 32'h0000_8888;
    cyc();
    check("ra_busy0", 32'(busy), 0);
    check("ra_ack0", 32'(bus.tgt_ack), 0);
    check("ra_lba0", bus.host_lba, 0);
    check("ra_id0", 32'(grant_id), 0);
    check("ra_req0", 32'({bus.host_rd, bus.host_wr, timeout_err}), 0);
    sbq.push_back('{3'd0, 32'h0000_7777});
    sbq.push_back('{3'd1, 32'h0000_8888});
    bus.host_ack = 1'b0;
    rst = 1'b0;
    serve(2'b01, 1);
    serve(2'b10, 1);
    cyc();
    check("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
